axi_burst_read_master: RTL and testbench
========================================

# axi_burst_read_master

Bridges the cache-side burst read request channel to a full AXI4 read channel. Accepts one request (address + burst length) from the requester, issues a single INCR burst on AR, collects R beats, and forwards each beat to the requester with a one-cycle strobe followed by a completion pulse. It sits directly downstream of the instruction cache refill logic and upstream of the AXI read slave / memory model.

## Interface
Parameters:
- AXI_ID, default 0: constant driven on arid; also the expected rid.
- BURST_TYPE, default 2'b01 (INCR): constant driven on arburst.

Ports (clock and reset first; the requester side is the axi_read_master_if handler modport, the bus side is the axi_read_if master modport):
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- read_req  input  1  level request; sampled only in IDLE.
- read_addr  input  32  burst start byte address; bits [1:0] ignored.
- read_len  input  8  AXI arlen encoding: beats = read_len + 1.
- read_ready  output  1  one-cycle strobe per beat; read_data valid while high.
- read_done  output  1  one-cycle pulse marking the end of the burst.
- read_data  output  32  registered beat data.
- arid, araddr, arlen, arsize, arburst, arvalid  output  per _axi_defines  AR channel.
- arready  input  1.
- rid, rdata, rresp, rlast, rvalid  input  per _axi_defines  R channel.
- rready  output  1.
- read_err  output  1  present only with AXI_RD_CHECK_EN.

## Operation
- States: IDLE, ADDR, DATA, DONE.
- IDLE:
  - If read_req = 1, latch araddr = {read_addr[31:2], 2'b00} and arlen = read_len.
  - Set arvalid = 1 and go to ADDR.
- ADDR:
  - Hold arvalid, araddr and arlen stable until arvalid & arready.
  - On that handshake, clear arvalid, set rready = 1 and go to DATA.
- DATA: on each rvalid & rready:
  - Register read_data <= rdata.
  - Pulse read_ready = 1 for the next cycle.
  - If rlast = 1, clear rready and go to DONE.
- DONE:
  - read_done = 1 for exactly this one cycle, coincident with the last beat's read_ready.
  - Then go to IDLE.
- Fixed AR fields: arsize = 3'b010, arburst = BURST_TYPE, arid = AXI_ID.
- rready is high only in DATA. No backpressure exists toward the requester; it must consume every strobe.
- The burst terminates on rlast only, never on a beat count.
- The requester must drop read_req in the read_done cycle. If read_req is still high on return to IDLE, the block starts a new burst.

## Timing
- Request sampled at edge N → arvalid high from cycle N+1.
- arready high in cycle N+1 → rready high from cycle N+2.
- Beat accepted at edge k → read_ready and read_data valid in cycle k+1.
- Last beat accepted at edge k → read_ready and read_done both high in cycle k+1; IDLE in k+2.
- Earliest next request acceptance: edge k+2.
- Minimum total for a single-beat burst: request edge to read_done is 3 cycles with zero-wait slave.
- Back-to-back beats (rvalid held high) produce consecutive read_ready cycles.
- Reset values: arvalid 0, rready 0, araddr 0, arlen 0, read_ready 0, read_done 0, read_data 0, read_err 0, state IDLE. arid, arsize and arburst are constants.
- Reset mid-burst: the next cycle is IDLE with all outputs at their reset values. The outstanding burst is abandoned, because reset is system-wide.

## Configuration
- Macro: AXI_RD_CHECK_EN.
- Defined, the block adds:
  - the read_err port;
  - an 8-bit beat counter, cleared on AR handshake;
  - an error flag, set by any of: rresp != 2'b00, rid != AXI_ID, rlast on a beat other than beat index arlen, or beat index arlen arriving without rlast.
- The burst still ends only on rlast.
- read_err is valid in the read_done cycle, holds until the next request is accepted, and is cleared on that acceptance.
- Undefined: no counter, no read_err port, no response checking.

## Test plan
- Single beat: read_addr 0x1000, read_len 0, arready immediate, rdata 0xDEADBEEF with rlast → araddr 0x1000, arlen 0; one read_ready with 0xDEADBEEF, read_done in the same cycle.
- 8-beat burst, rvalid continuous, data 0..7 → eight consecutive read_ready cycles carrying 0..7; read_done with data 7; rready low afterward.
- AR stall: arready low for 5 cycles → arvalid, araddr and arlen stable all 5 cycles; no rready until the handshake.
- Unaligned address 0x2003 with gapped rvalid (1 cycle on, 2 off, 4 beats) → araddr 0x2000; read_ready only after each accepted beat; 4 strobes total.
- Reset asserted mid-DATA after 2 of 4 beats → next cycle all outputs 0 and state IDLE; a new request then completes normally.
- With AXI_RD_CHECK_EN: read_len 3, rlast on beat 2 → burst ends and read_err = 1 with read_done. Repeat with rresp = 2'b10 on beat 1 → read_err = 1. Clean burst → read_err = 0.

Source files
------------

// File: rtl/axi_burst_read_master.sv
// Single-burst AXI4 read master: one request -> one INCR burst on AR -> beats strobed to the requester.
// Optional response checking (beat counter + read_err port) is enabled by defining AXI_RD_CHECK_EN.
module axi_burst_read_master #(
    parameter int unsigned      ID_W       = 4,
    parameter logic [ID_W-1:0]  AXI_ID     = '0,
    parameter logic [1:0]       BURST_TYPE = 2'b01
) (
    input  logic            clk,
    input  logic            rst,
    // requester side
    input  logic            read_req,
    input  logic [31:0]     read_addr,
    input  logic [7:0]      read_len,
    output logic            read_ready,
    output logic            read_done,
    output logic [31:0]     read_data,
    // AR channel
    output logic [ID_W-1:0] arid,
    output logic [31:0]     araddr,
    output logic [7:0]      arlen,
    output logic [2:0]      arsize,
    output logic [1:0]      arburst,
    output logic            arvalid,
    input  logic            arready,
    // R channel
    input  logic [ID_W-1:0] rid,
    input  logic [31:0]     rdata,
    input  logic [1:0]      rresp,
    input  logic            rlast,
    input  logic            rvalid,
`ifdef AXI_RD_CHECK_EN
    output logic            read_err,
`endif
    output logic            rready
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]  state_q,      state_d;
    logic        arvalid_q,    arvalid_d;
    logic        rready_q,     rready_d;
    logic [31:0] araddr_q,     araddr_d;
    logic [7:0]  arlen_q,      arlen_d;
    logic        read_ready_q, read_ready_d;
    logic        read_done_q,  read_done_d;
    logic [31:0] read_data_q,  read_data_d;

    logic ar_hs;
    logic r_beat;
    logic req_accept;

    assign ar_hs      = (state_q == S_ADDR) && arvalid_q && arready;
    assign r_beat     = (state_q == S_DATA) && rvalid && rready_q;
    assign req_accept = (state_q == S_IDLE) && read_req;

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d      = state_q;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;
        araddr_d     = araddr_q;
        arlen_d      = arlen_q;
        read_data_d  = read_data_q;
        read_ready_d = 1'b0;
        read_done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (read_req) begin
                    araddr_d  = {read_addr[31:2], 2'b00};
                    arlen_d   = read_len;
                    arvalid_d = 1'b1;
                    state_d   = S_ADDR;
                end
            end
            S_ADDR: begin
                if (ar_hs) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (r_beat) begin
                    read_data_d  = rdata;
                    read_ready_d = 1'b1;
                    // Only rlast ends the burst; the beat count is never trusted for termination.
                    if (rlast) begin
                        rready_d    = 1'b0;
                        read_done_d = 1'b1;
                        state_d     = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q      <= S_IDLE;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            araddr_q     <= '0;
            arlen_q      <= '0;
            read_ready_q <= 1'b0;
            read_done_q  <= 1'b0;
            read_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            araddr_q     <= araddr_d;
            arlen_q      <= arlen_d;
            read_ready_q <= read_ready_d;
            read_done_q  <= read_done_d;
            read_data_q  <= read_data_d;
        end
    end

    assign arid       = AXI_ID;
    assign arsize     = 3'b010;
    assign arburst    = BURST_TYPE;
    assign arvalid    = arvalid_q;
    assign araddr     = araddr_q;
    assign arlen      = arlen_q;
    assign rready     = rready_q;
    assign read_ready = read_ready_q;
    assign read_done  = read_done_q;
    assign read_data  = read_data_q;

    // Word alignment discards the byte offset.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^read_addr[1:0];

`ifdef AXI_RD_CHECK_EN
    logic [7:0] beat_cnt_q, beat_cnt_d;
    logic       err_q,      err_d;
    logic       beat_bad;

    // A beat is bad if its response/ID is wrong or rlast disagrees with the expected final index.
    assign beat_bad = (rresp != 2'b00) || (rid != AXI_ID) || (rlast != (beat_cnt_q == arlen_q));

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        err_d      = err_q;
        if (req_accept) begin
            err_d = 1'b0;
        end
        if (ar_hs) begin
            beat_cnt_d = '0;
        end else if (r_beat) begin
            beat_cnt_d = beat_cnt_q + 8'd1;
            if (beat_bad) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
        end
    end

    assign read_err = err_q;
`else
    logic unused_resp;
    logic unused_accept;
    assign unused_resp   = ^{rid, rresp};
    assign unused_accept = req_accept;
`endif

endmodule

// File: tb/tb_axi_burst_read_master.sv
// Directed bench for axi_burst_read_master; also exercises response checking when AXI_RD_CHECK_EN is defined.
module tb_axi_burst_read_master;

    localparam int unsigned ID_W = 4;

    logic            clk;
    logic            rst;
    logic            read_req;
    logic [31:0]     read_addr;
    logic [7:0]      read_len;
    logic            read_ready;
    logic            read_done;
    logic [31:0]     read_data;
    logic [ID_W-1:0] arid;
    logic [31:0]     araddr;
    logic [7:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic            arvalid;
    logic            arready;
    logic [ID_W-1:0] rid;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
    logic            rready;
`ifdef AXI_RD_CHECK_EN
    logic            read_err;
`endif

    axi_burst_read_master #(
        .ID_W       (ID_W),
        .AXI_ID     ('0),
        .BURST_TYPE (2'b01)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .read_req   (read_req),
        .read_addr  (read_addr),
        .read_len   (read_len),
        .read_ready (read_ready),
        .read_done  (read_done),
        .read_data  (read_data),
        .arid       (arid),
        .araddr     (araddr),
        .arlen      (arlen),
        .arsize     (arsize),
        .arburst    (arburst),
        .arvalid    (arvalid),
        .arready    (arready),
        .rid        (rid),
        .rdata      (rdata),
        .rresp      (rresp),
        .rlast      (rlast),
        .rvalid     (rvalid),
`ifdef AXI_RD_CHECK_EN
        .read_err   (read_err),
`endif
        .rready     (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    // Strobe monitor, sampled on the falling edge.
    logic [31:0] strobe_data[$];
    int          strobe_cyc[$];
    int          done_cnt;
    logic [31:0] done_data;
    logic        done_with_ready;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (read_ready) begin
            strobe_data.push_back(read_data);
            strobe_cyc.push_back(cyc);
        end
        if (read_done) begin
            done_cnt++;
            done_data       = read_data;
            done_with_ready = read_ready;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        strobe_data.delete();
        strobe_cyc.delete();
        done_cnt        = 0;
        done_data       = '0;
        done_with_ready = 1'b0;
    endtask

    // One full burst. Beat i carries base+i; rlast on beat last_at; rresp=SLVERR on beat bad_at.
    task automatic do_burst(input logic [31:0] addr, input logic [31:0] exp_araddr,
                            input logic [7:0] len, input int ar_wait, input int gap,
                            input int n_beats, input int last_at, input int bad_at,
                            input logic [31:0] base, input logic exp_err);
        clear_mon();
        read_req  = 1'b1;
        read_addr = addr;
        read_len  = len;
        tick();
        read_req  = 1'b0;
        check("arvalid_up", arvalid, 1'b1);
        check("araddr", araddr, exp_araddr);
        check("arlen", {24'd0, arlen}, {24'd0, len});
`ifdef AXI_RD_CHECK_EN
        check("err_cleared_on_accept", read_err, 1'b0);
`endif
        for (int w = 0; w < ar_wait; w++) begin
            tick();
            check("stall_arvalid", arvalid, 1'b1);
            check("stall_araddr", araddr, exp_araddr);
            check("stall_arlen", {24'd0, arlen}, {24'd0, len});
            check("stall_rready", rready, 1'b0);
        end
        arready = 1'b1;
        tick();
        arready = 1'b0;
        check("rready_up", rready, 1'b1);
        check("arvalid_down", arvalid, 1'b0);
        for (int i = 0; i < n_beats; i++) begin
            repeat (gap) tick();
            rvalid = 1'b1;
            rdata  = base + i;
            rlast  = (i == last_at);
            rresp  = (i == bad_at) ? 2'b10 : 2'b00;
            tick();
            rvalid = 1'b0;
            rlast  = 1'b0;
            rresp  = 2'b00;
            if (i == last_at) break;
        end
        check("done_cycle_done", read_done, 1'b1);
        check("done_cycle_ready", read_ready, 1'b1);
`ifdef AXI_RD_CHECK_EN
        check("read_err", read_err, exp_err);
`else
        if (exp_err) $display("note: error expectation ignored without response checking");
`endif
        tick();
        check("after_done_rready", rready, 1'b0);
        check("after_done_done", read_done, 1'b0);
        check("after_done_ready", read_ready, 1'b0);
        check("done_count", done_cnt, 1);
    endtask

    initial begin
        rst       = 1'b1;
        read_req  = 1'b0;
        read_addr = '0;
        read_len  = '0;
        arready   = 1'b0;
        rid       = '0;
        rdata     = '0;
        rresp     = 2'b00;
        rlast     = 1'b0;
        rvalid    = 1'b0;
        clear_mon();
        repeat (3) tick();

        // Reset values and constant AR fields
        check("rst_arvalid", arvalid, 1'b0);
        check("rst_rready", rready, 1'b0);
        check("rst_araddr", araddr, 32'h0);
        check("rst_arlen", {24'd0, arlen}, 32'h0);
        check("rst_read_ready", read_ready, 1'b0);
        check("rst_read_done", read_done, 1'b0);
        check("rst_read_data", read_data, 32'h0);
        check("arsize", {29'd0, arsize}, 32'h2);
        check("arburst", {30'd0, arburst}, 32'h1);
        check("arid", {28'd0, arid}, 32'h0);
        rst = 1'b0;
        tick();

        // Single beat, zero-wait slave
        do_burst(32'h0000_1000, 32'h0000_1000, 8'd0, 0, 0, 1, 0, -1, 32'hDEAD_BEEF, 1'b0);
        check("t1_strobes", strobe_data.size(), 1);
        if (strobe_data.size() == 1) check("t1_data", strobe_data[0], 32'hDEAD_BEEF);
        check("t1_done_data", done_data, 32'hDEAD_BEEF);
        check("t1_done_with_ready", done_with_ready, 1'b1);

        // 8-beat burst, rvalid continuous, data 0..7
        do_burst(32'h0000_4000, 32'h0000_4000, 8'd7, 0, 0, 8, 7, -1, 32'h0, 1'b0);
        check("t2_strobes", strobe_data.size(), 8);
        if (strobe_data.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                check("t2_data", strobe_data[i], i);
                check("t2_consecutive", strobe_cyc[i] - strobe_cyc[0], i);
            end
        end
        check("t2_done_data", done_data, 32'h7);

        // AR stall of 5 cycles
        do_burst(32'h0000_3000, 32'h0000_3000, 8'd1, 5, 0, 2, 1, -1, 32'h100, 1'b0);
        check("t3_strobes", strobe_data.size(), 2);
        if (strobe_data.size() == 2) check("t3_data1", strobe_data[1], 32'h101);

        // Unaligned address, gapped rvalid (2 idle cycles before each beat)
        do_burst(32'h0000_2003, 32'h0000_2000, 8'd3, 0, 2, 4, 3, -1, 32'h55AA_0000, 1'b0);
        check("t4_strobes", strobe_data.size(), 4);
        if (strobe_data.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check("t4_data", strobe_data[i], 32'h55AA_0000 + i);
                check("t4_spacing", strobe_cyc[i] - strobe_cyc[0], 3 * i);
            end
        end

        // Reset mid-DATA after 2 of 4 beats
        read_req  = 1'b1;
        read_addr = 32'h0000_6000;
        read_len  = 8'd3;
        tick();
        read_req = 1'b0;
        arready  = 1'b1;
        tick();
        arready = 1'b0;
        rvalid  = 1'b1;
        rdata   = 32'h1;
        tick();
        rdata = 32'h2;
        tick();
        rvalid = 1'b0;
        check("t5_pre_rst_ready", read_ready, 1'b1);
        check("t5_pre_rst_data", read_data, 32'h2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_arvalid", arvalid, 1'b0);
        check("t5_rready", rready, 1'b0);
        check("t5_araddr", araddr, 32'h0);
        check("t5_arlen", {24'd0, arlen}, 32'h0);
        check("t5_read_ready", read_ready, 1'b0);
        check("t5_read_done", read_done, 1'b0);
        check("t5_read_data", read_data, 32'h0);
`ifdef AXI_RD_CHECK_EN
        check("t5_read_err", read_err, 1'b0);
`endif
        do_burst(32'h0000_5004, 32'h0000_5004, 8'd1, 0, 0, 2, 1, -1, 32'hC0DE_0000, 1'b0);
        check("t6_strobes", strobe_data.size(), 2);
        if (strobe_data.size() == 2) check("t6_data0", strobe_data[0], 32'hC0DE_0000);

`ifdef AXI_RD_CHECK_EN
        // Early rlast: len 3, rlast on beat 2
        do_burst(32'h0000_7000, 32'h0000_7000, 8'd3, 0, 0, 4, 2, -1, 32'h10, 1'b1);
        check("t7_strobes", strobe_data.size(), 3);
        // SLVERR on beat 1
        do_burst(32'h0000_7100, 32'h0000_7100, 8'd3, 0, 0, 4, 3, 1, 32'h20, 1'b1);
        // Clean burst clears the flag
        do_burst(32'h0000_7200, 32'h0000_7200, 8'd3, 0, 0, 4, 3, -1, 32'h30, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
